// File: rtl/rm_ihpsg13_bist_pkg.sv
// ============================================================================
// rm_ihpsg13_bist_pkg : shared types and March C- element table for the BIST
// Revision: 1.0
// ============================================================================
`default_nettype none

package rm_ihpsg13_bist_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // rd=1 reads, rd=0 writes; val=0 refers to BG, val=1 to ~BG
   typedef struct packed {
      logic down;
      logic two_ops;
      logic rd0;
      logic val0;
      logic rd1;
      logic val1;
   } elem_t;

   localparam int          N_ELEM    = 6;
   localparam int          ERR_CNT_W = 8;
   localparam logic [2:0]  LAST_ELEM = 3'd5;

   // Fields left to right: down, two_ops, rd0, val0, rd1, val1
   localparam elem_t [0:N_ELEM-1] MARCH_TBL = {
      elem_t'(6'b000000),   // up   (w0)
      elem_t'(6'b011001),   // up   (r0,w1)
      elem_t'(6'b011100),   // up   (r1,w0)
      elem_t'(6'b111001),   // down (r0,w1)
      elem_t'(6'b111100),   // down (r1,w0)
      elem_t'(6'b001000)    // up   (r0)
   };

endpackage

`default_nettype wire

// File: rtl/rm_ihpsg13_bist_march_ctrl_if.sv
// ============================================================================
// rm_ihpsg13_bist_march_ctrl_if : SRAM BIST port and status bundle
// Revision: 1.0
// ============================================================================
`default_nettype none

interface rm_ihpsg13_bist_march_ctrl_if
   import rm_ihpsg13_bist_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 16
);
   logic                 BIST_START;
   logic                 A_BIST_EN;
   logic                 A_BIST_MEN;
   logic                 A_BIST_WEN;
   logic                 A_BIST_REN;
   logic [ADDR_W-1:0]    A_BIST_ADDR;
   logic [DATA_W-1:0]    A_BIST_DIN;
   logic [DATA_W-1:0]    A_BIST_BM;
   logic [DATA_W-1:0]    A_DOUT;
   logic                 BIST_BUSY;
   logic                 BIST_DONE;
   logic                 BIST_FAIL;
   logic [ADDR_W-1:0]    BIST_FAIL_ADDR;
   logic [DATA_W-1:0]    BIST_FAIL_DATA;
   logic [ERR_CNT_W-1:0] BIST_ERR_CNT;

   modport master (
      input  BIST_START, A_DOUT,
      output A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN, A_BIST_ADDR,
             A_BIST_DIN, A_BIST_BM, BIST_BUSY, BIST_DONE, BIST_FAIL,
             BIST_FAIL_ADDR, BIST_FAIL_DATA, BIST_ERR_CNT
   );

   modport slave (
      output BIST_START, A_DOUT,
      input  A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN, A_BIST_ADDR,
             A_BIST_DIN, A_BIST_BM, BIST_BUSY, BIST_DONE, BIST_FAIL,
             BIST_FAIL_ADDR, BIST_FAIL_DATA, BIST_ERR_CNT
   );

endinterface

`default_nettype wire

// File: rtl/rm_ihpsg13_bist_cmp.sv
// ============================================================================
// rm_ihpsg13_bist_cmp : read shadow, compare, first-fail capture, error count
// Revision: 1.0
// ============================================================================
`default_nettype none

module rm_ihpsg13_bist_cmp
   import rm_ihpsg13_bist_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 16
) (
   input  wire logic                 clk,
   input  wire logic                 rst,
   input  wire logic                 clear,
   input  wire logic                 rd_valid,
   input  wire logic [ADDR_W-1:0]    rd_addr,
   input  wire logic [DATA_W-1:0]    rd_exp,
   input  wire logic [DATA_W-1:0]    dout,
   output logic                      fail,
   output logic [ADDR_W-1:0]         fail_addr,
   output logic [DATA_W-1:0]         fail_data,
   output logic [ERR_CNT_W-1:0]      err_cnt
);

   logic              sh_valid;
   logic [ADDR_W-1:0] sh_addr;
   logic [DATA_W-1:0] sh_exp;
   logic              mismatch;

   // Case inequality also flags X/Z read data in simulation
   assign mismatch = sh_valid && (dout !== sh_exp);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         sh_valid  <= 1'b0;
         sh_addr   <= '0;
         sh_exp    <= '0;
         fail      <= 1'b0;
         fail_addr <= '0;
         fail_data <= '0;
         err_cnt   <= '0;
      end else begin
         sh_valid <= rd_valid;
         sh_addr  <= rd_addr;
         sh_exp   <= rd_exp;
         if (mismatch) begin
            if (!fail) begin
               fail_addr <= sh_addr;
               fail_data <= dout;
            end
            fail <= 1'b1;
            if (err_cnt != {ERR_CNT_W{1'b1}})
               err_cnt <= err_cnt + 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/rm_ihpsg13_bist_march_ctrl.sv
// ============================================================================
// rm_ihpsg13_bist_march_ctrl : March C- BIST FSM and address/element sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

module rm_ihpsg13_bist_march_ctrl
   import rm_ihpsg13_bist_pkg::*;
#(
   parameter int                 ADDR_W = 10,
   parameter int                 DATA_W = 16,
   parameter logic [DATA_W-1:0]  BG     = '0
) (
   input  wire logic                  A_BIST_CLK,
   input  wire logic                  A_BIST_RST,
   rm_ihpsg13_bist_march_ctrl_if.master bus
);

   localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};
   localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;

   state_t            state, state_nxt;
   logic [2:0]        elem, elem_nxt;
   logic              op, op_nxt;
   logic [ADDR_W-1:0] addr, addr_nxt;
   logic              start_acc;
   elem_t             cur, follow, ne;
   logic              run_nxt, busy_nxt, rd_nxt, inv_nxt;
   logic [DATA_W-1:0] pat_nxt, exp_q;

   always_comb begin
      state_nxt = state;
      elem_nxt  = elem;
      op_nxt    = op;
      addr_nxt  = addr;
      start_acc = 1'b0;
      cur       = MARCH_TBL[elem];
      follow    = (elem == LAST_ELEM) ? MARCH_TBL[0] : MARCH_TBL[elem + 3'd1];

      case (state)
         ST_IDLE, ST_DONE: begin
            if (bus.BIST_START) begin
               start_acc = 1'b1;
               state_nxt = ST_RUN;
               elem_nxt  = 3'd0;
               op_nxt    = 1'b0;
               addr_nxt  = ADDR_ZERO;
            end
         end
         ST_RUN: begin
            if (cur.two_ops && !op) begin
               op_nxt = 1'b1;
            end else begin
               op_nxt = 1'b0;
               if (addr == (cur.down ? ADDR_ZERO : ADDR_MAX)) begin
                  if (elem == LAST_ELEM) begin
                     state_nxt = ST_DRAIN;
                  end else begin
                     // Next element starts on the very next cycle, no gap
                     elem_nxt = elem + 3'd1;
                     addr_nxt = follow.down ? ADDR_MAX : ADDR_ZERO;
                  end
               end else begin
                  addr_nxt = cur.down ? (addr - 1'b1) : (addr + 1'b1);
               end
            end
         end
         ST_DRAIN: state_nxt = ST_DONE;
         default:  state_nxt = ST_IDLE;
      endcase

      ne       = MARCH_TBL[elem_nxt];
      rd_nxt   = op_nxt ? ne.rd1 : ne.rd0;
      inv_nxt  = op_nxt ? ne.val1 : ne.val0;
      pat_nxt  = inv_nxt ? ~BG : BG;
      run_nxt  = (state_nxt == ST_RUN);
      busy_nxt = run_nxt || (state_nxt == ST_DRAIN);
   end

   always_ff @(posedge A_BIST_CLK) begin
      if (A_BIST_RST) begin
         state           <= ST_IDLE;
         elem            <= 3'd0;
         op              <= 1'b0;
         addr            <= '0;
         exp_q           <= '0;
         bus.A_BIST_EN   <= 1'b0;
         bus.A_BIST_MEN  <= 1'b0;
         bus.A_BIST_WEN  <= 1'b0;
         bus.A_BIST_REN  <= 1'b0;
         bus.A_BIST_ADDR <= '0;
         bus.A_BIST_DIN  <= '0;
         bus.A_BIST_BM   <= '0;
         bus.BIST_BUSY   <= 1'b0;
         bus.BIST_DONE   <= 1'b0;
      end else begin
         state           <= state_nxt;
         elem            <= elem_nxt;
         op              <= op_nxt;
         addr            <= addr_nxt;
         exp_q           <= pat_nxt;
         bus.A_BIST_EN   <= busy_nxt;
         bus.A_BIST_MEN  <= run_nxt;
         bus.A_BIST_WEN  <= run_nxt && !rd_nxt;
         bus.A_BIST_REN  <= run_nxt && rd_nxt;
         bus.A_BIST_ADDR <= run_nxt ? addr_nxt : '0;
         bus.A_BIST_DIN  <= (run_nxt && !rd_nxt) ? pat_nxt : '0;
         bus.A_BIST_BM   <= run_nxt ? {DATA_W{1'b1}} : '0;
         bus.BIST_BUSY   <= busy_nxt;
         bus.BIST_DONE   <= (state_nxt == ST_DONE);
      end
   end

   rm_ihpsg13_bist_cmp #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_cmp (
      .clk       (A_BIST_CLK),
      .rst       (A_BIST_RST),
      .clear     (start_acc),
      .rd_valid  (bus.A_BIST_REN),
      .rd_addr   (bus.A_BIST_ADDR),
      .rd_exp    (exp_q),
      .dout      (bus.A_DOUT),
      .fail      (bus.BIST_FAIL),
      .fail_addr (bus.BIST_FAIL_ADDR),
      .fail_data (bus.BIST_FAIL_DATA),
      .err_cnt   (bus.BIST_ERR_CNT)
   );

endmodule

`default_nettype wire

// File: tb/tb_rm_ihpsg13_bist_march_ctrl.sv
// ============================================================================
// tb_rm_ihpsg13_bist_march_ctrl : directed bench with behavioural SRAM model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rm_ihpsg13_bist_march_ctrl;
   import rm_ihpsg13_bist_pkg::*;

   localparam int AW      = 10;
   localparam int DW      = 16;
   localparam int N       = 1024;
   localparam int RUN_CYC = 10 * N + 2;
   localparam int MAX_CYC = 12000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   rm_ihpsg13_bist_march_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bif ();

   rm_ihpsg13_bist_march_ctrl #(.ADDR_W(AW), .DATA_W(DW), .BG(16'h0000)) u_dut (
      .A_BIST_CLK (clk),
      .A_BIST_RST (rst),
      .bus        (bif.master)
   );

   // Behavioural SRAM with optional stuck-at-1 on bit 3 of 0x155 and a forced-zero output
   logic [DW-1:0] mem [N];
   logic [DW-1:0] dout_raw = '0;
   bit            stuck_en = 1'b0;
   bit            force_zero = 1'b0;

   always @(posedge clk) begin
      if (bif.A_BIST_EN && bif.A_BIST_MEN) begin
         if (bif.A_BIST_WEN)
            mem[bif.A_BIST_ADDR] <= (mem[bif.A_BIST_ADDR] & ~bif.A_BIST_BM) | (bif.A_BIST_DIN & bif.A_BIST_BM);
         if (bif.A_BIST_REN)
            dout_raw <= mem[bif.A_BIST_ADDR] | ((stuck_en && bif.A_BIST_ADDR == 10'h155) ? 16'h0008 : 16'h0000);
      end
   end
   assign bif.A_DOUT = force_zero ? 16'h0000 : dout_raw;

   typedef struct packed {
      logic          en, men, wen, ren, busy, done, fail;
      logic [AW-1:0] addr;
      logic [AW-1:0] faddr;
      logic [DW-1:0] din, bm;
      logic [7:0]    err;
   } snap_t;

   snap_t tr [0:MAX_CYC];
   int    tests = 0;
   int    fails = 0;

   // tr[k] holds the bus/status seen just after the k-th edge counted from the start edge
   task automatic run_start(input int stop_at, input int repulse_at, output int cycles, output bit timeout);
      bit fin;
      @(negedge clk);
      bif.BIST_START = 1'b1;
      cycles  = 0;
      timeout = 1'b0;
      fin     = 1'b0;
      while (!fin) begin
         @(posedge clk);
         #1;
         cycles++;
         tr[cycles].en    = bif.A_BIST_EN;
         tr[cycles].men   = bif.A_BIST_MEN;
         tr[cycles].wen   = bif.A_BIST_WEN;
         tr[cycles].ren   = bif.A_BIST_REN;
         tr[cycles].busy  = bif.BIST_BUSY;
         tr[cycles].done  = bif.BIST_DONE;
         tr[cycles].fail  = bif.BIST_FAIL;
         tr[cycles].addr  = bif.A_BIST_ADDR;
         tr[cycles].faddr = bif.BIST_FAIL_ADDR;
         tr[cycles].din   = bif.A_BIST_DIN;
         tr[cycles].bm    = bif.A_BIST_BM;
         tr[cycles].err   = bif.BIST_ERR_CNT;
         bif.BIST_START = (cycles == repulse_at);
         if (bif.BIST_DONE === 1'b1 || cycles == stop_at) fin = 1'b1;
         if (cycles >= MAX_CYC) begin
            timeout = 1'b1;
            fin     = 1'b1;
         end
      end
      bif.BIST_START = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bif.BIST_START = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      tests++; if (bif.A_BIST_EN !== 1'b0) begin fails++; $display("FAIL reset_en got=%b exp=0", bif.A_BIST_EN); end
      tests++; if ({bif.A_BIST_MEN, bif.A_BIST_WEN, bif.A_BIST_REN} !== 3'b000) begin fails++; $display("FAIL reset_ctl got=%b exp=000", {bif.A_BIST_MEN, bif.A_BIST_WEN, bif.A_BIST_REN}); end
      tests++; if ({bif.BIST_BUSY, bif.BIST_DONE, bif.BIST_FAIL} !== 3'b000) begin fails++; $display("FAIL reset_status got=%b exp=000", {bif.BIST_BUSY, bif.BIST_DONE, bif.BIST_FAIL}); end
      tests++; if (bif.BIST_ERR_CNT !== 8'd0) begin fails++; $display("FAIL reset_errcnt got=%0d exp=0", bif.BIST_ERR_CNT); end
      tests++; if ({bif.A_BIST_ADDR, bif.A_BIST_DIN, bif.A_BIST_BM} !== 42'd0) begin fails++; $display("FAIL reset_bus got=%h exp=0", {bif.A_BIST_ADDR, bif.A_BIST_DIN, bif.A_BIST_BM}); end
      @(negedge clk);
      bif.BIST_START = 1'b0;
      rst = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_fault_free();
      int cyc; bit to; int bad; int first_bad;
      run_start(0, 0, cyc, to);
      tests++; if (to || cyc !== RUN_CYC) begin fails++; $display("FAIL ff_latency got=%0d exp=%0d timeout=%0b", cyc, RUN_CYC, to); end
      tests++; if (bif.BIST_FAIL !== 1'b0 || bif.BIST_ERR_CNT !== 8'd0) begin fails++; $display("FAIL ff_result got fail=%b err=%0d exp fail=0 err=0", bif.BIST_FAIL, bif.BIST_ERR_CNT); end
      tests++; if ({bif.BIST_DONE, bif.BIST_BUSY, bif.A_BIST_EN} !== 3'b100) begin fails++; $display("FAIL ff_done got=%b exp=100", {bif.BIST_DONE, bif.BIST_BUSY, bif.A_BIST_EN}); end
      tests++; if ({tr[1].busy, tr[1].en} !== 2'b11) begin fails++; $display("FAIL ff_first_busy got=%b exp=11", {tr[1].busy, tr[1].en}); end
      bad = 0; first_bad = -1;
      for (int k = 0; k < N; k++) begin
         if ({tr[k+1].men, tr[k+1].wen, tr[k+1].ren} !== 3'b110 || tr[k+1].addr !== AW'(k) ||
             tr[k+1].din !== 16'h0000 || tr[k+1].bm !== 16'hFFFF) begin
            bad++;
            if (first_bad < 0) first_bad = k;
         end
      end
      tests++; if (bad !== 0) begin fails++; $display("FAIL ff_e0_trace got=%0d bad ops (first op %0d) exp=0", bad, first_bad); end
      tests++; if ({tr[N+1].men, tr[N+1].wen, tr[N+1].ren} !== 3'b101 || tr[N+1].addr !== 10'h000 || tr[N+1].din !== 16'h0000) begin
         fails++; $display("FAIL ff_e1_r0 got ctl=%b addr=%h din=%h exp ctl=101 addr=000 din=0000", {tr[N+1].men, tr[N+1].wen, tr[N+1].ren}, tr[N+1].addr, tr[N+1].din); end
      tests++; if ({tr[N+2].men, tr[N+2].wen, tr[N+2].ren} !== 3'b110 || tr[N+2].addr !== 10'h000 || tr[N+2].din !== 16'hFFFF) begin
         fails++; $display("FAIL ff_e1_w1 got ctl=%b addr=%h din=%h exp ctl=110 addr=000 din=ffff", {tr[N+2].men, tr[N+2].wen, tr[N+2].ren}, tr[N+2].addr, tr[N+2].din); end
   endtask

   // Uses the trace left by the fault-free run
   task automatic test_e2_e3();
      tests++; if ({tr[5120].wen, tr[5120].ren} !== 2'b10 || tr[5120].addr !== 10'h3FF || tr[5120].din !== 16'h0000) begin
         fails++; $display("FAIL e2_last_w0 got wr=%b addr=%h din=%h exp wr=10 addr=3ff din=0000", {tr[5120].wen, tr[5120].ren}, tr[5120].addr, tr[5120].din); end
      tests++; if ({tr[5121].men, tr[5121].ren} !== 2'b11 || tr[5121].addr !== 10'h3FF) begin
         fails++; $display("FAIL e3_first_r0 got menren=%b addr=%h exp menren=11 addr=3ff", {tr[5121].men, tr[5121].ren}, tr[5121].addr); end
      tests++; if (tr[5122].wen !== 1'b1 || tr[5122].addr !== 10'h3FF || tr[5122].din !== 16'hFFFF) begin
         fails++; $display("FAIL e3_first_w1 got wen=%b addr=%h din=%h exp wen=1 addr=3ff din=ffff", tr[5122].wen, tr[5122].addr, tr[5122].din); end
      tests++; if (tr[5123].ren !== 1'b1 || tr[5123].addr !== 10'h3FE) begin
         fails++; $display("FAIL e3_down got ren=%b addr=%h exp ren=1 addr=3fe", tr[5123].ren, tr[5123].addr); end
      tests++; if (tr[7168].wen !== 1'b1 || tr[7168].addr !== 10'h000 || tr[7169].ren !== 1'b1 || tr[7169].addr !== 10'h3FF) begin
         fails++; $display("FAIL e3_e4_turn got w=%b a=%h r=%b a=%h exp w=1 a=000 r=1 a=3ff", tr[7168].wen, tr[7168].addr, tr[7169].ren, tr[7169].addr); end
      tests++; if (tr[10240].ren !== 1'b1 || tr[10240].addr !== 10'h3FF) begin
         fails++; $display("FAIL e5_last got ren=%b addr=%h exp ren=1 addr=3ff", tr[10240].ren, tr[10240].addr); end
      tests++; if ({tr[10241].en, tr[10241].men, tr[10241].busy, tr[10241].done, tr[10241].bm} !== {4'b1010, 16'h0000}) begin
         fails++; $display("FAIL drain got en/men/busy/done=%b bm=%h exp 1010 bm=0000", {tr[10241].en, tr[10241].men, tr[10241].busy, tr[10241].done}, tr[10241].bm); end
   endtask

   task automatic test_stuck_bit();
      int cyc; bit to;
      stuck_en = 1'b1;
      run_start(0, 0, cyc, to);
      stuck_en = 1'b0;
      tests++; if (to || cyc !== RUN_CYC) begin fails++; $display("FAIL stuck_latency got=%0d exp=%0d", cyc, RUN_CYC); end
      tests++; if (bif.BIST_FAIL !== 1'b1 || bif.BIST_FAIL_ADDR !== 10'h155) begin fails++; $display("FAIL stuck_addr got fail=%b addr=%h exp fail=1 addr=155", bif.BIST_FAIL, bif.BIST_FAIL_ADDR); end
      tests++; if (bif.BIST_FAIL_DATA !== 16'h0008) begin fails++; $display("FAIL stuck_data got=%h exp=0008", bif.BIST_FAIL_DATA); end
      tests++; if (bif.BIST_ERR_CNT !== 8'd3) begin fails++; $display("FAIL stuck_errcnt got=%0d exp=3", bif.BIST_ERR_CNT); end
   endtask

   // Starts from DONE with failing results and re-pulses start mid-run
   task automatic test_back_to_back();
      int cyc; bit to;
      run_start(0, 3000, cyc, to);
      tests++; if ({tr[1].done, tr[1].fail, tr[1].busy} !== 3'b001 || tr[1].err !== 8'd0 || tr[1].faddr !== 10'h000) begin
         fails++; $display("FAIL restart_clear got done/fail/busy=%b err=%0d faddr=%h exp 001 err=0 faddr=000", {tr[1].done, tr[1].fail, tr[1].busy}, tr[1].err, tr[1].faddr); end
      tests++; if (to || cyc !== RUN_CYC) begin fails++; $display("FAIL b2b_latency got=%0d exp=%0d", cyc, RUN_CYC); end
      tests++; if (bif.BIST_FAIL !== 1'b0 || bif.BIST_ERR_CNT !== 8'd0) begin fails++; $display("FAIL b2b_result got fail=%b err=%0d exp fail=0 err=0", bif.BIST_FAIL, bif.BIST_ERR_CNT); end
   endtask

   task automatic test_dout_zero();
      int cyc; bit to;
      force_zero = 1'b1;
      run_start(0, 0, cyc, to);
      force_zero = 1'b0;
      tests++; if (to || cyc !== RUN_CYC) begin fails++; $display("FAIL zero_latency got=%0d exp=%0d", cyc, RUN_CYC); end
      tests++; if (bif.BIST_FAIL !== 1'b1 || bif.BIST_FAIL_ADDR !== 10'h000 || bif.BIST_FAIL_DATA !== 16'h0000) begin
         fails++; $display("FAIL zero_first got fail=%b addr=%h data=%h exp fail=1 addr=000 data=0000", bif.BIST_FAIL, bif.BIST_FAIL_ADDR, bif.BIST_FAIL_DATA); end
      tests++; if (bif.BIST_ERR_CNT !== 8'd255) begin fails++; $display("FAIL zero_saturate got=%0d exp=255", bif.BIST_ERR_CNT); end
   endtask

   task automatic test_reset_mid_run();
      int cyc; bit to;
      force_zero = 1'b1;
      run_start(5000, 0, cyc, to);
      tests++; if (bif.BIST_BUSY !== 1'b1 || bif.BIST_ERR_CNT !== 8'd255) begin fails++; $display("FAIL mid_prestate got busy=%b err=%0d exp busy=1 err=255", bif.BIST_BUSY, bif.BIST_ERR_CNT); end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      tests++; if ({bif.A_BIST_EN, bif.A_BIST_MEN, bif.A_BIST_WEN, bif.A_BIST_REN, bif.BIST_BUSY, bif.BIST_DONE, bif.BIST_FAIL} !== 7'd0) begin
         fails++; $display("FAIL mid_reset_ctl got=%b exp=0000000", {bif.A_BIST_EN, bif.A_BIST_MEN, bif.A_BIST_WEN, bif.A_BIST_REN, bif.BIST_BUSY, bif.BIST_DONE, bif.BIST_FAIL}); end
      tests++; if ({bif.BIST_ERR_CNT, bif.BIST_FAIL_ADDR, bif.BIST_FAIL_DATA, bif.A_BIST_ADDR, bif.A_BIST_DIN, bif.A_BIST_BM} !== 76'd0) begin
         fails++; $display("FAIL mid_reset_data got err=%0d fa=%h fd=%h a=%h d=%h bm=%h exp all 0", bif.BIST_ERR_CNT, bif.BIST_FAIL_ADDR, bif.BIST_FAIL_DATA, bif.A_BIST_ADDR, bif.A_BIST_DIN, bif.A_BIST_BM); end
      @(negedge clk);
      rst = 1'b0;
      force_zero = 1'b0;
      run_start(0, 0, cyc, to);
      tests++; if (to || cyc !== RUN_CYC || bif.BIST_FAIL !== 1'b0 || bif.BIST_ERR_CNT !== 8'd0) begin
         fails++; $display("FAIL mid_rerun got cyc=%0d fail=%b err=%0d exp cyc=%0d fail=0 err=0", cyc, bif.BIST_FAIL, bif.BIST_ERR_CNT, RUN_CYC); end
   endtask

   initial begin
      bif.BIST_START = 1'b0;
      test_reset();
      test_fault_free();
      test_e2_e3();
      test_stuck_bit();
      test_back_to_back();
      test_dout_zero();
      test_reset_mid_run();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
